// File: rtl/blood_abnormality_monitor_if.sv
// Sample/result valid-ready bus for blood_abnormality_monitor.
// master = sensor/alarm side, slave = monitor.
interface blood_abnormality_monitor_if #(
   parameter int CH_W = 2,
   parameter int PH_W = 4
);
   logic            sampleValid;
   logic            sampleReady;
   logic [CH_W-1:0] sampleChannel;
   logic [PH_W-1:0] bloodPH;
   logic [2:0]      bloodType;
   logic            resultValid;
   logic            resultReady;
   logic [CH_W-1:0] resultChannel;
   logic            resultAbnormal;

   modport master (
      output sampleValid, sampleChannel, bloodPH, bloodType,
      output resultReady,
      input  sampleReady, resultValid, resultChannel, resultAbnormal
   );

   modport slave (
      input  sampleValid, sampleChannel, bloodPH, bloodType,
      input  resultReady,
      output sampleReady, resultValid, resultChannel, resultAbnormal
   );
endinterface

// File: rtl/blood_abnormality_monitor.sv
// Multi-channel blood pH classifier with per-channel consecutive alarms.
// Optional macro BLOOD_STICKY_ALARM_EN: normal samples do not clear alarms.
module blood_abnormality_monitor #(
   parameter int NUM_CH  = 4,
   parameter int PH_W    = 4,
   parameter int PH_LO_A = 4,
   parameter int PH_HI_A = 6,
   parameter int PH_LO_B = 5,
   parameter int PH_HI_B = 7,
   parameter int CONSEC  = 3,
   parameter int CNT_W   = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   blood_abnormality_monitor_if.slave bus,
   output logic [NUM_CH-1:0]   alarm,
   input  logic [NUM_CH-1:0]   alarmAck,
   output logic [CNT_W-1:0]    abnormalTotal
);
   localparam int RUN_W = $clog2(CONSEC + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CONSEC);
   localparam logic [PH_W-1:0] LO_A = PH_W'(PH_LO_A);
   localparam logic [PH_W-1:0] HI_A = PH_W'(PH_HI_A);
   localparam logic [PH_W-1:0] LO_B = PH_W'(PH_LO_B);
   localparam logic [PH_W-1:0] HI_B = PH_W'(PH_HI_B);

   logic             accept;
   logic             consume;
   logic             reserved;
   logic             inWinA;
   logic             inWinB;
   logic             isAbnormal;
   logic             inRange;
   logic [RUN_W-1:0] runCnt  [NUM_CH];
   logic [RUN_W-1:0] runNext [NUM_CH];
   logic [NUM_CH-1:0] alarmNext;

   assign bus.sampleReady = !rst &&
      (!bus.resultValid || bus.resultReady);
   assign accept  = bus.sampleValid && bus.sampleReady;
   assign consume = bus.resultValid && bus.resultReady;

   assign reserved = bus.bloodType inside {3'd6, 3'd7};
   assign inWinA = (bus.bloodPH >= LO_A) && (bus.bloodPH <= HI_A);
   assign inWinB = (bus.bloodPH >= LO_B) && (bus.bloodPH <= HI_B);
   assign isAbnormal = reserved ||
      (bus.bloodType[1] ? !inWinB : !inWinA);
   assign inRange = {1'b0, bus.sampleChannel} < (CH_W+1)'(NUM_CH);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         runNext[i]   = runCnt[i];
         alarmNext[i] = alarm[i] & ~alarmAck[i];
         if (accept && inRange &&
             bus.sampleChannel == CH_W'(i)) begin
            if (isAbnormal) begin
               if (runCnt[i] != RUN_MAX)
                  runNext[i] = runCnt[i] + 1'b1;
               // a saturated run re-arms the alarm on every abnormal sample
               if (runNext[i] == RUN_MAX)
                  alarmNext[i] = 1'b1;
            end else begin
               runNext[i] = '0;
`ifndef BLOOD_STICKY_ALARM_EN
               alarmNext[i] = 1'b0;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.resultValid    <= 1'b0;
         bus.resultChannel  <= '0;
         bus.resultAbnormal <= 1'b0;
         alarm              <= '0;
         abnormalTotal      <= '0;
         for (int i = 0; i < NUM_CH; i++)
            runCnt[i] <= '0;
      end else begin
         if (accept) begin
            bus.resultValid    <= 1'b1;
            bus.resultChannel  <= bus.sampleChannel;
            bus.resultAbnormal <= isAbnormal;
            if (isAbnormal && !(&abnormalTotal))
               abnormalTotal <= abnormalTotal + 1'b1;
         end else if (consume) begin
            bus.resultValid <= 1'b0;
         end
         alarm <= alarmNext;
         for (int i = 0; i < NUM_CH; i++)
            runCnt[i] <= runNext[i];
      end
   end
endmodule
